// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one memory port between instruction fetch (IFU) and
//            load/store (LSU). One transaction in flight at a time. LSU has
//            fixed priority, with a starvation guard that forces an IFU grant
//            after STARVE_LIMIT consecutive LSU grants while IFU is waiting.
//            A response timeout returns 32'hDEADBEEF plus an err pulse.
// Ports    : clk_i, rst_ni              clock / async active-low reset
//            ifu_req_*_i/o, ifu_addr_i  IFU read request handshake
//            ifu_rvalid_o, ifu_rdata_o  IFU response (one-cycle pulse)
//            lsu_req_*_i/o, lsu_*_i     LSU load/store request handshake
//            lsu_rvalid_o, lsu_rdata_o  LSU response (one-cycle pulse)
//            mem_req_*_o/i, mem_*_o     latched request towards memory
//            mem_rvalid_i, mem_rdata_i  memory response
//            err_o                      one-cycle pulse on response timeout
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 1023
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // IFU
  input  logic        ifu_req_valid_i,
  output logic        ifu_req_ready_o,
  input  logic [31:0] ifu_addr_i,
  output logic        ifu_rvalid_o,
  output logic [31:0] ifu_rdata_o,
  // LSU
  input  logic        lsu_req_valid_i,
  output logic        lsu_req_ready_o,
  input  logic [31:0] lsu_addr_i,
  input  logic        lsu_wen_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic [7:0]  lsu_wmask_i,
  output logic        lsu_rvalid_o,
  output logic [31:0] lsu_rdata_o,
  // Memory
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_wen_o,
  output logic [31:0] mem_wdata_o,
  output logic [7:0]  mem_wmask_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        err_o
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_MAX  = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT);
  localparam logic [31:0]   TIMEOUT_DATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IFU  = 2'd1,
    OWN_LSU  = 2'd2
  } owner_e;

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [31:0]   addr_q,  addr_d;
  logic          wen_q,   wen_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [7:0]    wmask_q, wmask_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [TW-1:0] tmo_q,   tmo_d;

  logic          starved;
  logic          resp_valid;
  logic          resp_tmo;
  logic [31:0]   resp_data;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      owner_q  <= OWN_NONE;
      addr_q   <= '0;
      wen_q    <= 1'b0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      starve_q <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      wen_q    <= wen_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      starve_q <= starve_d;
      tmo_q    <= tmo_d;
    end
  end

  // IFU only counts as starved while it is actually asking.
  assign starved = (starve_q == STARVE_MAX) && ifu_req_valid_i;

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    addr_d          = addr_q;
    wen_d           = wen_q;
    wdata_d         = wdata_q;
    wmask_d         = wmask_q;
    starve_d        = starve_q;
    tmo_d           = tmo_q;
    ifu_req_ready_o = 1'b0;
    lsu_req_ready_o = 1'b0;
    resp_valid      = 1'b0;
    resp_tmo        = 1'b0;
    resp_data       = '0;

    unique case (state_q)
      S_IDLE: begin
        if (lsu_req_valid_i && !starved) begin
          lsu_req_ready_o = 1'b1;
          owner_d = OWN_LSU;
          addr_d  = lsu_addr_i;
          wen_d   = lsu_wen_i;
          wdata_d = lsu_wdata_i;
          // Reads never carry a byte mask to memory.
          wmask_d = lsu_wen_i ? lsu_wmask_i : 8'h00;
          if (ifu_req_valid_i && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
          end
          state_d = S_ISSUE;
        end else if (ifu_req_valid_i) begin
          ifu_req_ready_o = 1'b1;
          owner_d  = OWN_IFU;
          addr_d   = ifu_addr_i;
          wen_d    = 1'b0;
          wdata_d  = '0;
          wmask_d  = 8'h00;
          starve_d = '0;
          state_d  = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (mem_req_ready_i) begin
          tmo_d   = '0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        // A real response in the same cycle as the timeout still wins.
        if (mem_rvalid_i) begin
          resp_valid = 1'b1;
          resp_data  = mem_rdata_i;
          owner_d    = OWN_NONE;
          state_d    = S_IDLE;
        end else if (tmo_q == TIMEOUT_MAX) begin
          resp_valid = 1'b1;
          resp_tmo   = 1'b1;
          resp_data  = TIMEOUT_DATA;
          owner_d    = OWN_NONE;
          state_d    = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
      end
    endcase

    // Grants are combinational on the request inputs; hold them off in reset.
    if (!rst_ni) begin
      ifu_req_ready_o = 1'b0;
      lsu_req_ready_o = 1'b0;
    end
  end

  // Response routing to the owner; rdata is zero whenever rvalid is low.
  always_comb begin
    ifu_rvalid_o = 1'b0;
    ifu_rdata_o  = '0;
    lsu_rvalid_o = 1'b0;
    lsu_rdata_o  = '0;
    if (resp_valid) begin
      if (owner_q == OWN_IFU) begin
        ifu_rvalid_o = 1'b1;
        ifu_rdata_o  = resp_data;
      end else if (owner_q == OWN_LSU) begin
        lsu_rvalid_o = 1'b1;
        lsu_rdata_o  = (wen_q && !resp_tmo) ? 32'h0 : resp_data;
      end
    end
  end

  assign err_o           = resp_tmo;
  assign mem_req_valid_o = (state_q == S_ISSUE);
  assign mem_addr_o      = addr_q;
  assign mem_wen_o       = wen_q;
  assign mem_wdata_o     = wdata_q;
  assign mem_wmask_o     = wmask_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed bench for mem_port_arbiter: a per-cycle vector table
//            for basic traffic, plus hand sequences for starvation, timeout
//            and asynchronous reset mid-transaction.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_req_valid, ifu_req_ready, ifu_rvalid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rvalid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [7:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_rvalid, err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(1023)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ifu_req_valid_i(ifu_req_valid), .ifu_req_ready_o(ifu_req_ready),
    .ifu_addr_i(ifu_addr), .ifu_rvalid_o(ifu_rvalid), .ifu_rdata_o(ifu_rdata),
    .lsu_req_valid_i(lsu_req_valid), .lsu_req_ready_o(lsu_req_ready),
    .lsu_addr_i(lsu_addr), .lsu_wen_i(lsu_wen), .lsu_wdata_i(lsu_wdata),
    .lsu_wmask_i(lsu_wmask), .lsu_rvalid_o(lsu_rvalid), .lsu_rdata_o(lsu_rdata),
    .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
    .mem_addr_o(mem_addr), .mem_wen_o(mem_wen), .mem_wdata_o(mem_wdata),
    .mem_wmask_o(mem_wmask), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .err_o(err)
  );

  // All outputs in one word: readies, mem request, ifu rsp, lsu rsp, err.
  logic [142:0] act_all;
  assign act_all = {ifu_req_ready, lsu_req_ready, mem_req_valid, mem_addr, mem_wen,
                    mem_wdata, mem_wmask, ifu_rvalid, ifu_rdata, lsu_rvalid, lsu_rdata, err};

  typedef struct {
    logic iv; logic [31:0] ia;
    logic lv; logic [31:0] la; logic lw; logic [31:0] ld; logic [7:0] lm;
    logic mr; logic mv; logic [31:0] md;
    logic [142:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic iv, input logic [31:0] ia,
    input logic lv, input logic [31:0] la, input logic lw, input logic [31:0] ld,
    input logic [7:0] lm, input logic mr, input logic mv, input logic [31:0] md,
    input logic e_ir, input logic e_lr, input logic e_mv, input logic [31:0] e_ma,
    input logic e_mw, input logic [31:0] e_md, input logic [7:0] e_mm,
    input logic e_iv, input logic [31:0] e_id, input logic e_lv, input logic [31:0] e_ld,
    input logic e_err);
    vec_t v;
    v.iv = iv; v.ia = ia; v.lv = lv; v.la = la; v.lw = lw; v.ld = ld; v.lm = lm;
    v.mr = mr; v.mv = mv; v.md = md;
    v.exp = {e_ir, e_lr, e_mv, e_ma, e_mw, e_md, e_mm, e_iv, e_id, e_lv, e_ld, e_err};
    return v;
  endfunction

  task automatic check(input string name, input logic [142:0] act, input logic [142:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] ia, input logic lv,
                       input logic [31:0] la, input logic lw, input logic [31:0] ld,
                       input logic [7:0] lm, input logic mr, input logic mv,
                       input logic [31:0] md);
    ifu_req_valid = iv; ifu_addr = ia;
    lsu_req_valid = lv; lsu_addr = la; lsu_wen = lw; lsu_wdata = ld; lsu_wmask = lm;
    mem_req_ready = mr; mem_rvalid = mv; mem_rdata = md;
  endtask

  // Drive just after the rising edge, sample on the falling edge.
  task automatic step(input logic iv, input logic [31:0] ia, input logic lv,
                      input logic [31:0] la, input logic lw, input logic [31:0] ld,
                      input logic [7:0] lm, input logic mr, input logic mv,
                      input logic [31:0] md);
    @(posedge clk);
    #1;
    drive(iv, ia, lv, la, lw, ld, lm, mr, mv, md);
    @(negedge clk);
  endtask

  initial begin
    int n;
    int grants;
    logic [9:0] pattern;
    logic ifu_seen;

    // ---------------- vector table ----------------
    // IFU-only read, response one cycle after issue
    vecs.push_back(mk(H,32'h80000000, L,0,L,0,8'h00, L,L,0,          H,L,L,32'h0,L,0,8'h00, L,0,L,0,L));
    vecs.push_back(mk(L,0, L,0,L,0,8'h00, H,L,0,                     L,L,H,32'h80000000,L,0,8'h00, L,0,L,0,L));
    vecs.push_back(mk(L,0, L,0,L,0,8'h00, L,H,32'h00100073,          L,L,L,32'h80000000,L,0,8'h00, H,32'h00100073,L,0,L));
    vecs.push_back(mk(L,0, L,0,L,0,8'h00, L,L,0,                     L,L,L,32'h80000000,L,0,8'h00, L,0,L,0,L));
    // Simultaneous requests: LSU store first, then IFU
    vecs.push_back(mk(H,32'h80000004, H,32'h80001000,H,32'h12345678,8'h0F, L,L,0, L,H,L,32'h80000000,L,0,8'h00, L,0,L,0,L));
    vecs.push_back(mk(H,32'h80000004, L,0,L,0,8'h00, H,L,0,          L,L,H,32'h80001000,H,32'h12345678,8'h0F, L,0,L,0,L));
    vecs.push_back(mk(H,32'h80000004, L,0,L,0,8'h00, L,H,32'hAAAA5555, L,L,L,32'h80001000,H,32'h12345678,8'h0F, L,0,H,0,L));
    vecs.push_back(mk(H,32'h80000004, L,0,L,0,8'h00, L,L,0,          H,L,L,32'h80001000,H,32'h12345678,8'h0F, L,0,L,0,L));
    vecs.push_back(mk(L,0, L,0,L,0,8'h00, H,L,0,                     L,L,H,32'h80000004,L,0,8'h00, L,0,L,0,L));
    vecs.push_back(mk(L,0, L,0,L,0,8'h00, L,H,32'h00000013,          L,L,L,32'h80000004,L,0,8'h00, H,32'h00000013,L,0,L));
    vecs.push_back(mk(L,0, L,0,L,0,8'h00, L,L,0,                     L,L,L,32'h80000004,L,0,8'h00, L,0,L,0,L));
    // Memory not ready for 5 cycles: request held stable, no new grant
    vecs.push_back(mk(H,32'h80000008, L,0,L,0,8'h00, L,L,0,          H,L,L,32'h80000004,L,0,8'h00, L,0,L,0,L));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(H,32'h8000000C, L,0,L,0,8'h00, L,L,0,        L,L,H,32'h80000008,L,0,8'h00, L,0,L,0,L));
    vecs.push_back(mk(H,32'h8000000C, L,0,L,0,8'h00, H,L,0,          L,L,H,32'h80000008,L,0,8'h00, L,0,L,0,L));
    vecs.push_back(mk(H,32'h8000000C, L,0,L,0,8'h00, L,H,32'h11112222, L,L,L,32'h80000008,L,0,8'h00, H,32'h11112222,L,0,L));
    vecs.push_back(mk(H,32'h8000000C, L,0,L,0,8'h00, L,L,0,          H,L,L,32'h80000008,L,0,8'h00, L,0,L,0,L));
    vecs.push_back(mk(L,0, L,0,L,0,8'h00, H,L,0,                     L,L,H,32'h8000000C,L,0,8'h00, L,0,L,0,L));
    vecs.push_back(mk(L,0, L,0,L,0,8'h00, L,H,32'h33334444,          L,L,L,32'h8000000C,L,0,8'h00, H,32'h33334444,L,0,L));
    // Stray response while idle is ignored
    vecs.push_back(mk(L,0, L,0,L,0,8'h00, L,H,32'h55556666,          L,L,L,32'h8000000C,L,0,8'h00, L,0,L,0,L));
    // LSU load: mask forced to 0, load data returned
    vecs.push_back(mk(L,0, H,32'h80002000,L,0,8'h0F, L,L,0,          L,H,L,32'h8000000C,L,0,8'h00, L,0,L,0,L));
    vecs.push_back(mk(L,0, L,0,L,0,8'h00, H,L,0,                     L,L,H,32'h80002000,L,0,8'h00, L,0,L,0,L));
    vecs.push_back(mk(L,0, L,0,L,0,8'h00, L,H,32'hCAFEF00D,          L,L,L,32'h80002000,L,0,8'h00, L,0,H,32'hCAFEF00D,L));
    vecs.push_back(mk(L,0, L,0,L,0,8'h00, L,L,0,                     L,L,L,32'h80002000,L,0,8'h00, L,0,L,0,L));

    // ---------------- reset state ----------------
    rst_n = 1'b0;
    drive(H, 32'h80000000, H, 32'h80001000, H, 32'h1, 8'h0F, H, H, 32'hFFFFFFFF);
    @(negedge clk);
    check("reset_outputs", act_all, '0);
    drive(L, 0, L, 0, L, 0, 8'h00, L, L, 0);
    #2 rst_n = 1'b1;

    // ---------------- table ----------------
    foreach (vecs[i]) begin
      step(vecs[i].iv, vecs[i].ia, vecs[i].lv, vecs[i].la, vecs[i].lw, vecs[i].ld,
           vecs[i].lm, vecs[i].mr, vecs[i].mv, vecs[i].md);
      check($sformatf("vec%0d", i), act_all, vecs[i].exp);
    end

    // ---------------- starvation guard ----------------
    // Both always requesting; grant order must be 4 LSU then 1 IFU, twice.
    grants = 0; pattern = '0;
    step(H, 32'h80005000, H, 32'h80006000, L, 0, 8'h00, H, H, 32'h77);
    for (int c = 0; c < 60 && grants < 10; c++) begin
      if (c != 0) begin
        @(posedge clk); #1; @(negedge clk);
      end
      if (ifu_req_ready) begin pattern[grants] = 1'b1; grants++; end
      else if (lsu_req_ready) begin grants++; end
    end
    check("starve_grant_count", 143'(grants), 143'(10));
    check("starve_pattern", 143'(pattern), 143'(10'b10000_10000));
    // drain the last transaction
    step(L, 0, L, 0, L, 0, 8'h00, H, H, 32'h77);
    step(L, 0, L, 0, L, 0, 8'h00, H, H, 32'h77);
    step(L, 0, L, 0, L, 0, 8'h00, L, L, 0);
    check("starve_drained_idle", act_all,
          {3'b000, 32'h80005000, 1'b0, 32'h0, 8'h00, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0});

    // ---------------- timeout ----------------
    step(L, 0, H, 32'h80007000, L, 0, 8'h00, L, L, 0);
    check("tmo_grant", 143'(lsu_req_ready), 143'(1));
    step(L, 0, L, 0, L, 0, 8'h00, H, L, 0);
    check("tmo_issue", 143'(mem_req_valid), 143'(1));
    n = 0;
    ifu_seen = 1'b0;
    for (int c = 0; c < 1100; c++) begin
      step(L, 0, L, 0, L, 0, 8'h00, L, L, 0);
      if (lsu_rvalid) begin ifu_seen = 1'b1; break; end
      n++;
    end
    check("tmo_responded", 143'(ifu_seen), 143'(1));
    check("tmo_wait_cycles", 143'(n), 143'(1023));
    check("tmo_response", 143'({ifu_rvalid, lsu_rvalid, lsu_rdata, err}),
          143'({1'b0, 1'b1, 32'hDEADBEEF, 1'b1}));
    step(L, 0, L, 0, L, 0, 8'h00, L, H, 32'h12121212);
    check("tmo_late_rsp_ignored", 143'({ifu_rvalid, ifu_rdata, lsu_rvalid, lsu_rdata, err, mem_req_valid}),
          143'(0));

    // ---------------- async reset while in WAIT ----------------
    step(H, 32'h80008000, L, 0, L, 0, 8'h00, L, L, 0);
    check("rst_seq_grant", 143'(ifu_req_ready), 143'(1));
    step(L, 0, L, 0, L, 0, 8'h00, H, L, 0);
    step(L, 0, L, 0, L, 0, 8'h00, L, L, 0);
    check("rst_seq_in_wait", 143'({mem_req_valid, ifu_rvalid, mem_addr}),
          143'({1'b0, 1'b0, 32'h80008000}));
    drive(H, 32'h80009000, H, 32'h80009100, H, 32'h5, 8'h0F, H, H, 32'h99999999);
    #1 rst_n = 1'b0;
    #1 check("rst_async_outputs", act_all, '0);
    drive(L, 0, L, 0, L, 0, 8'h00, L, H, 32'h99999999);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_dropped_txn", act_all, '0);
    step(H, 32'h8000A000, L, 0, L, 0, 8'h00, L, L, 0);
    check("rst_fresh_grant", act_all, {3'b100, 32'h0, 1'b0, 32'h0, 8'h00, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0});
    step(L, 0, L, 0, L, 0, 8'h00, H, L, 0);
    check("rst_fresh_issue", 143'({mem_req_valid, mem_addr, mem_wen}), 143'({1'b1, 32'h8000A000, 1'b0}));
    step(L, 0, L, 0, L, 0, 8'h00, L, H, 32'h0BADF00D);
    check("rst_fresh_rsp", 143'({ifu_rvalid, ifu_rdata, lsu_rvalid}), 143'({1'b1, 32'h0BADF00D, 1'b0}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
